// File: rtl/encoder_r32i_if.sv
// Request/response bus of the RV32I encoder: a field-level request channel in,
// a packed instruction word channel out, and the illegal-request pulse.
interface encoder_r32i_if #(
  parameter int dataW = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op_class;
  logic [2:0]       funct3;
  logic             alt;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [dataW-1:0] imm;
  logic             out_valid;
  logic             out_ready;
  logic [dataW-1:0] out_ins;
  logic             out_last;
  logic             err;

  modport slave (
    input  in_valid, op_class, funct3, alt, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_ins, out_last, err
  );

  modport master (
    output in_valid, op_class, funct3, alt, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_ins, out_last, err
  );
endinterface

// File: rtl/encoder_r32i.sv
// Sequential RV32I encoder: range-checks a field-level request, packs it into a
// 32-bit instruction word and expands LI into LUI(+ADDI).
module encoder_r32i #(
  parameter int dataW = 32
) (
  input  logic               clk,
  input  logic               nReset,
  encoder_r32i_if.slave      bus,
  output logic [1:0]         o_dbg_state
);
  // Handshake: a request transfers on in_valid & in_ready at a rising edge, a
  // word on out_valid & out_ready; a held word never changes until it transfers.

  localparam logic [6:0] OP_OPPI   = 7'b0010011;
  localparam logic [6:0] OP_OPPR   = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD  = 2'd1,
    S_HOLD2 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_out_valid;
  logic [dataW-1:0] r_out_ins;
  logic             r_out_last;
  logic [dataW-1:0] r_pend;
  logic             r_err;

  logic [dataW-1:0] w_imm;
  logic [4:0]       w_rd;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [2:0]       w_f3;
  logic             w_alt;
  logic             w_i_ok;
  logic             w_b_ok;
  logic             w_j_ok;
  logic             w_sh_ok;
  logic [dataW-1:0] w_li_sum;
  logic             w_illegal;
  logic             w_two;
  logic [dataW-1:0] w_word0;
  logic [dataW-1:0] w_word1;
  logic             w_accept;
  logic             w_out_hs;
  logic             w_take;
  logic             w_promote;

  assign w_imm    = bus.imm;
  assign w_rd     = bus.rd;
  assign w_rs1    = bus.rs1;
  assign w_rs2    = bus.rs2;
  assign w_f3     = bus.funct3;
  assign w_alt    = bus.alt;
  // A value fits a signed N-bit field when all bits above the sign bit match it.
  assign w_i_ok   = (w_imm[31:11] == '0) || (w_imm[31:11] == '1);
  assign w_b_ok   = ((w_imm[31:12] == '0) || (w_imm[31:12] == '1)) && !w_imm[0];
  assign w_j_ok   = ((w_imm[31:20] == '0) || (w_imm[31:20] == '1)) && !w_imm[0];
  assign w_sh_ok  = (w_imm[31:5] == '0);
  assign w_li_sum = w_imm + 32'h0000_0800;

  always_comb begin
    w_illegal = 1'b0;
    w_two     = 1'b0;
    w_word0   = '0;
    w_word1   = '0;
    case (bus.op_class)
      4'd0: begin
        if (w_f3 == 3'd1) begin
          w_illegal = !w_sh_ok || w_alt;
          w_word0   = {7'b0, w_imm[4:0], w_rs1, w_f3, w_rd, OP_OPPI};
        end else if (w_f3 == 3'd5) begin
          w_illegal = !w_sh_ok;
          w_word0   = {1'b0, w_alt, 5'b0, w_imm[4:0], w_rs1, w_f3, w_rd, OP_OPPI};
        end else begin
          w_illegal = !w_i_ok;
          w_word0   = {w_imm[11:0], w_rs1, w_f3, w_rd, OP_OPPI};
        end
      end
      4'd1: begin
        w_illegal = w_alt && !((w_f3 == 3'd0) || (w_f3 == 3'd5));
        w_word0   = {1'b0, w_alt, 5'b0, w_rs2, w_rs1, w_f3, w_rd, OP_OPPR};
      end
      4'd2, 4'd3: begin
        w_illegal = (w_imm[11:0] != 12'd0);
        w_word0   = {w_imm[31:12], w_rd, (bus.op_class == 4'd2) ? OP_LUI : OP_AUIPC};
      end
      4'd4: begin
        w_illegal = !w_j_ok;
        w_word0   = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], w_rd, OP_JAL};
      end
      4'd5: begin
        w_illegal = !w_i_ok || (w_f3 != 3'd0);
        w_word0   = {w_imm[11:0], w_rs1, 3'd0, w_rd, OP_JALR};
      end
      4'd6: begin
        w_illegal = !w_b_ok || (w_f3 == 3'd2) || (w_f3 == 3'd3);
        w_word0   = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, w_f3,
                     w_imm[4:1], w_imm[11], OP_BRANCH};
      end
      4'd7: begin
        w_illegal = !w_i_ok || (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
        w_word0   = {w_imm[11:0], w_rs1, w_f3, w_rd, OP_LOAD};
      end
      4'd8: begin
        w_illegal = !w_i_ok || (w_f3 > 3'd2);
        w_word0   = {w_imm[11:5], w_rs2, w_rs1, w_f3, w_imm[4:0], OP_STORE};
      end
      4'd9: begin
        if (w_i_ok) begin
          w_word0 = {w_imm[11:0], 5'd0, 3'd0, w_rd, OP_OPPI};
        end else begin
          // The +0x800 rounding in the upper part compensates the ADDI sign-extension.
          w_word0 = {w_li_sum[31:12], w_rd, OP_LUI};
          w_two   = (w_imm[11:0] != 12'd0);
          w_word1 = {w_imm[11:0], w_rd, 3'd0, w_rd, OP_OPPI};
        end
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign bus.in_ready = (r_state == S_EMPTY) || ((r_state == S_HOLD) && bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_out_hs     = r_out_valid && bus.out_ready;

  always_comb begin
    w_next    = r_state;
    w_take    = 1'b0;
    w_promote = 1'b0;
    case (r_state)
      S_EMPTY: w_take = w_accept;
      S_HOLD: begin
        if (w_out_hs) begin
          w_take = w_accept;
          w_next = S_EMPTY;
        end
      end
      S_HOLD2: begin
        if (w_out_hs) begin
          w_promote = 1'b1;
          w_next    = S_HOLD;
        end
      end
      default: w_next = S_EMPTY;
    endcase
    if (w_take) begin
      w_next = w_illegal ? S_EMPTY : (w_two ? S_HOLD2 : S_HOLD);
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_out_ins   <= '0;
      r_out_last  <= 1'b0;
      r_pend      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= (w_next != S_EMPTY);
      r_err       <= w_accept && w_illegal;
      if (w_take && !w_illegal) begin
        r_out_ins  <= w_word0;
        r_out_last <= !w_two;
        r_pend     <= w_word1;
      end else if (w_promote) begin
        r_out_ins  <= r_pend;
        r_out_last <= 1'b1;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_ins   = r_out_ins;
  assign bus.out_last  = r_out_last;
  assign bus.err       = r_err;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_encoder_r32i.sv
// Bench for encoder_r32i: directed requests, a field-level reference encoder
// feeding an expected-word queue, and a per-cycle output monitor.
module tb_encoder_r32i;
  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic [32:0] exp_q[$];
  logic [31:0] got_q[$];
  bit          exp_err = 1'b0;
  bit          stall_prev = 1'b0;
  logic [32:0] prev_word = '0;

  encoder_r32i_if #(.dataW(32)) bus ();

  encoder_r32i #(.dataW(32)) dut (
    .clk(clk), .nReset(nReset), .bus(bus), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference encoder ----------------
  function automatic logic [31:0] i_word(input int opc, input int f3, input int rd,
                                         input int rs1, input int immv);
    logic [31:0] v;
    v = (32'(immv) & 32'hFFF) << 20;
    return v | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(opc);
  endfunction

  function automatic void model(input int op, input int f3, input int alt, input int rd,
                                input int rs1, input int rs2, input logic [31:0] u,
                                output bit ill, output int n,
                                output logic [31:0] w0, output logic [31:0] w1);
    int s;
    int lo;
    bit i_rng;
    logic [31:0] hv;
    s = u;
    i_rng = (s >= -2048) && (s <= 2047);
    ill = 1'b0; n = 1; w0 = '0; w1 = '0;
    case (op)
      0: begin
        if (f3 == 1 || f3 == 5) begin
          ill = (s < 0) || (s > 31) || (f3 == 1 && alt == 1);
          w0 = i_word(19, f3, rd, rs1, s + ((f3 == 5 && alt == 1) ? 1024 : 0));
        end else begin
          ill = !i_rng;
          w0 = i_word(19, f3, rd, rs1, s);
        end
      end
      1: begin
        ill = (alt == 1) && !(f3 == 0 || f3 == 5);
        w0 = i_word(51, f3, rd, rs1, rs2 + alt * 1024);
      end
      2, 3: begin
        ill = (u % 4096) != 0;
        w0 = (u & 32'hFFFFF000) | (32'(rd) << 7) | ((op == 2) ? 32'h37 : 32'h17);
      end
      4: begin
        ill = (s % 2 != 0) || (s < -1048576) || (s > 1048574);
        w0 = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
           | (((u >> 12) & 255) << 12) | (32'(rd) << 7) | 32'h6F;
      end
      5: begin
        ill = (f3 != 0) || !i_rng;
        w0 = i_word(103, 0, rd, rs1, s);
      end
      6: begin
        ill = (s % 2 != 0) || (s < -4096) || (s > 4094) || f3 == 2 || f3 == 3;
        w0 = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (32'(rs2) << 20)
           | (32'(rs1) << 15) | (32'(f3) << 12) | (((u >> 1) & 15) << 8)
           | (((u >> 11) & 1) << 7) | 32'h63;
      end
      7: begin
        ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) || !i_rng;
        w0 = i_word(3, f3, rd, rs1, s);
      end
      8: begin
        ill = (f3 > 2) || !i_rng;
        w0 = (((u >> 5) & 127) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
           | (32'(f3) << 12) | ((u & 31) << 7) | 32'h23;
      end
      9: begin
        if (i_rng) begin
          w0 = i_word(19, 0, rd, 0, s);
        end else begin
          hv = (u + 32'h800) >> 12;
          lo = u - (hv << 12);
          w0 = (hv << 12) | (32'(rd) << 7) | 32'h37;
          if (lo != 0) begin
            n = 2;
            w1 = i_word(19, 0, rd, rd, lo);
          end
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) n = 0;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    bit ill;
    int n;
    logic [31:0] w0, w1;
    if (!mon_en) begin
      stall_prev = 1'b0;
      exp_err = 1'b0;
    end else begin
      check("err", bus.err, exp_err);
      if (bus.out_valid) begin
        if (stall_prev) check("stable", {bus.out_last, bus.out_ins}, prev_word);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected no word", bus.out_ins);
        end else begin
          check("word", {bus.out_last, bus.out_ins}, exp_q[0]);
          if (bus.out_ready) begin
            got_q.push_back(bus.out_ins);
            void'(exp_q.pop_front());
          end
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_word = {bus.out_last, bus.out_ins};
      exp_err = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        model(bus.op_class, bus.funct3, bus.alt, bus.rd, bus.rs1, bus.rs2, bus.imm,
              ill, n, w0, w1);
        exp_err = ill;
        if (n >= 1) exp_q.push_back({(n == 1), w0});
        if (n == 2) exp_q.push_back({1'b1, w1});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input int op, input int f3, input int alt, input int rd,
                       input int rs1, input int rs2, input logic [31:0] imm);
    bus.op_class = 4'(op);
    bus.funct3   = 3'(f3);
    bus.alt      = alt[0];
    bus.rd       = 5'(rd);
    bus.rs1      = 5'(rs1);
    bus.rs2      = 5'(rs2);
    bus.imm      = imm;
    bus.in_valid = 1'b1;
  endtask

  task automatic send(input int op, input int f3, input int alt, input int rd,
                      input int rs1, input int rs2, input logic [31:0] imm);
    bit done;
    done = 1'b0;
    drive(op, f3, alt, rd, rs1, rs2, imm);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    bit ill;
    int n;
    logic [31:0] w0, w1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op_class = '0; bus.funct3 = '0; bus.alt = 1'b0;
    bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;

    // pin the reference encoder against hand-computed words
    model(9, 0, 0, 5, 0, 0, 32'h12345FFF, ill, n, w0, w1);
    check("model_li_w0", w0, 32'h123462B7);
    check("model_li_w1", w1, 32'hFFF28293);
    check("model_li_n", n, 2);
    model(6, 0, 0, 0, 1, 2, 32'hFFFFFFFC, ill, n, w0, w1);
    check("model_beq", w0, 32'hFE208EE3);
    model(4, 0, 0, 1, 0, 0, 32'h00000800, ill, n, w0, w1);
    check("model_jal", w0, 32'h001000EF);

    #7;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_ins", bus.out_ins, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_err", bus.err, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_state", dbg_state, 0);
    @(posedge clk);
    #1 nReset = 1'b1;
    mon_en = 1'b1;
    bus.out_ready = 1'b1;

    // test-plan vectors at full throughput
    send(0, 0, 0, 1, 2, 0, 32'hFFFFFFFF);
    check("addi_last", bus.out_last, 1);
    send(8, 2, 0, 0, 4, 3, 32'd8);
    send(9, 0, 0, 5, 0, 0, 32'h12345FFF);
    check("hold2_in_ready", bus.in_ready, 0);
    check("hold2_state", dbg_state, 2);
    check("li_first_last", bus.out_last, 0);
    send(9, 0, 0, 6, 0, 0, 32'h00001000);
    send(6, 0, 0, 0, 1, 2, 32'hFFFFFFFC);
    send(0, 5, 1, 1, 1, 0, 32'd3);
    idle(4);
    check("lit_count", got_q.size(), 7);
    if (got_q.size() == 7) begin
      check("lit_addi", got_q[0], 32'hFFF10093);
      check("lit_sw", got_q[1], 32'h00322423);
      check("lit_li_w0", got_q[2], 32'h123462B7);
      check("lit_li_w1", got_q[3], 32'hFFF28293);
      check("lit_li_lui", got_q[4], 32'h00001337);
      check("lit_beq", got_q[5], 32'hFE208EE3);
      check("lit_srai", got_q[6], 32'h4030D093);
    end

    // backpressure: word held, next request waits, accepted on release
    bus.out_ready = 1'b0;
    send(0, 0, 0, 7, 0, 0, 32'd5);
    drive(8, 2, 0, 0, 4, 3, 32'd8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_ins", bus.out_ins, 32'h00500393);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    idle(3);

    // illegal requests, each followed by a legal one
    send(6, 0, 0, 0, 1, 2, 32'd3);
    check("ill_b_err", bus.err, 1);
    check("ill_b_valid", bus.out_valid, 0);
    send(0, 0, 0, 1, 0, 0, 32'd2048);
    check("ill_addi_err", bus.err, 1);
    check("ill_addi_valid", bus.out_valid, 0);
    idle(1);
    check("err_one_cycle", bus.err, 0);
    send(12, 0, 0, 1, 0, 0, 32'd0);
    check("ill_class_err", bus.err, 1);
    send(0, 0, 0, 9, 9, 0, 32'd100);
    send(12, 0, 0, 1, 0, 0, 32'd0);
    check("ill_in_hold_err", bus.err, 1);
    check("ill_in_hold_valid", bus.out_valid, 0);
    idle(2);

    // remaining formats and legality corners
    send(2, 0, 0, 10, 0, 0, 32'hABCDE000);
    send(3, 0, 0, 11, 0, 0, 32'h00001000);
    send(2, 0, 0, 10, 0, 0, 32'h00000010);
    send(4, 0, 0, 1, 0, 0, 32'hFFF00000);
    send(4, 0, 0, 1, 0, 0, 32'h00100000);
    send(5, 0, 0, 1, 2, 0, 32'hFFFFF800);
    send(5, 1, 0, 1, 2, 0, 32'd4);
    send(6, 5, 0, 0, 3, 4, 32'h00000FFE);
    send(6, 2, 0, 0, 3, 4, 32'd8);
    send(7, 4, 0, 8, 2, 0, 32'd2047);
    send(7, 3, 0, 8, 2, 0, 32'd0);
    send(8, 0, 0, 0, 2, 31, 32'hFFFFF800);
    send(8, 3, 0, 0, 2, 1, 32'd0);
    send(1, 0, 1, 3, 4, 5, 32'd0);
    send(1, 7, 1, 3, 4, 5, 32'd0);
    send(0, 1, 1, 1, 1, 0, 32'd2);
    send(0, 1, 0, 1, 1, 0, 32'd32);
    send(0, 7, 1, 1, 1, 0, 32'hFFFFF800);
    send(9, 0, 0, 0, 0, 0, 32'h80000000);
    send(9, 0, 0, 4, 0, 0, 32'hFFFFF7FF);
    send(9, 0, 0, 4, 0, 0, 32'hFFFFF800);
    idle(4);
    check("drain_mid", exp_q.size(), 0);

    // reset while the second LI word is pending
    bus.out_ready = 1'b0;
    send(9, 0, 0, 5, 0, 0, 32'h12345FFF);
    check("pre_rst_state", dbg_state, 2);
    @(negedge clk);
    mon_en = 1'b0;
    #2 nReset = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_ins", bus.out_ins, 0);
    check("async_rst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #1 nReset = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", bus.out_valid, 0);
      check("post_rst_in_ready", bus.in_ready, 1);
    end
    @(posedge clk);
    #1 mon_en = 1'b1;
    send(0, 0, 0, 1, 2, 0, 32'hFFFFFFFF);
    check("post_rst_word", bus.out_ins, 32'hFFF10093);
    idle(4);
    check("drain_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/encoder_r32i.md
# encoder_r32i

Sequential RV32I instruction encoder: accepts a field-level instruction request on a valid/ready handshake and emits the packed 32-bit RV32I instruction word, one word per output handshake. It is the inverse of the core's instruction decoder and sits between the on-chip program builder/test sequencer and instruction memory write port. It range-checks immediates and fields, flags illegal requests, and expands the `LI` pseudo-instruction into one or two words (`LUI`/`ADDI`).

## Interface
- `dataW`, 32, instruction/immediate width; only 32 is supported.
- `clk`  input  1  rising-edge clock.
- `nReset`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  request valid.
- `in_ready`  output  1  request accepted when `in_valid & in_ready` at a rising edge.
- `op_class`  input  4  format selector:
  - 0 OPPI, 1 OPPR, 2 LUI, 3 AUIPC, 4 JAL, 5 JALR.
  - 6 BRANCH, 7 LOAD, 8 STORE, 9 LI.
  - 10–15 illegal.
- `funct3`  input  3  funct3 field (ignored for LUI/AUIPC/JAL/LI; JALR requires 0).
- `alt`  input  1  instruction bit 30 request (SUB/SRA/SRAI).
- `rd`, `rs1`, `rs2`  input  5 each  register addresses.
- `imm`  input  dataW  signed byte-offset/value immediate.
- `out_valid`  output  1  `out_ins` valid.
- `out_ready`  input  1  consumer accepts the word on `out_valid & out_ready`.
- `out_ins`  output  dataW  encoded instruction.
- `out_last`  output  1  final word of the current request.
- `err`  output  1  one-cycle pulse: last accepted request was illegal.

## Operation
- Opcodes:
  - OPPI 0010011, OPPR 0110011.
  - LUI 0110111, AUIPC 0010111.
  - JAL 1101111, JALR 1100111.
  - BRANCH 1100011, LOAD 0000011, STORE 0100011.
- Immediate placement follows the standard I/S/B/U/J layouts.
- Legality rules; any violation gives an illegal request:
  - I/S immediates: -2048..2047.
  - OPPI shifts (funct3 1, 5): `imm` must be 0..31. Bit 30 = `alt` only for funct3 5. `alt` with funct3 1 is illegal; `alt` with other funct3 values is ignored.
  - OPPR: `alt` is legal only with funct3 0 or 5.
  - B: `imm` even, -4096..4094; funct3 2 and 3 are illegal.
  - J: `imm` even, -1048576..1048574.
  - U: `imm[11:0]` must be 0; `imm[31:12]` is placed directly.
  - LOAD funct3 ∈ {0,1,2,4,5}; STORE funct3 ∈ {0,1,2}.
- An illegal request is still consumed: `err` pulses and no word is produced.
- LI rd, imm:
  - If `imm` is in -2048..2047: emit ADDI rd, x0, imm (one word, `out_last`=1).
  - Otherwise: lo = sign-extended `imm[11:0]`, hi = (`imm` + 0x800)[31:12], with 32-bit wrap.
  - Emit LUI rd, hi. If lo ≠ 0, follow with ADDI rd, rd, lo.
  - `out_last` is 1 only on the final word.
- `rd`=0 is encoded as given; it is not an error.
- States:
  - EMPTY: no word held.
  - HOLD: word held, nothing pending.
  - HOLD2: LI first word held, second word pending in an internal register.
- Transitions:
  - EMPTY --accept legal--> HOLD or HOLD2.
  - EMPTY --accept illegal--> EMPTY.
  - HOLD --out handshake, no accept--> EMPTY.
  - HOLD --out handshake with accept--> HOLD/HOLD2/EMPTY according to the new request.
  - HOLD2 --out handshake--> HOLD, with the second word and `out_last`=1.
- `in_ready` = EMPTY | (HOLD & `out_ready`), combinational from state and `out_ready`; it is 0 in HOLD2.

## Timing
- Reset (asynchronous, immediate):
  - `out_valid`=0, `out_ins`=0, `out_last`=0, `err`=0.
  - State EMPTY, so `in_ready`=1.
  - A pending LI second word is discarded.
- Latency: a word accepted at edge N is on `out_ins` with `out_valid`=1 after edge N.
- Throughput: one word per cycle with `out_ready` held high. An LI expanding to two words blocks input for one extra cycle.
- `out_ins`, `out_last` and `out_valid` are stable while `out_valid & !out_ready`.
- `err` is high for exactly the cycle after an illegal accept, otherwise 0.
- If an illegal request is accepted in HOLD together with an output handshake, the next state is EMPTY (`out_valid`=0) and `err`=1.
- All outputs are registered except `in_ready`.

## Test plan
- ADDI x1, x2, -1 (class 0, f3 0, `imm`=0xFFFFFFFF) -> `out_ins`=0xFFF10093, `out_last`=1 one cycle after accept. SW x3, 8(x4) (class 8, f3 2) -> 0x00322423.
- LI x5, 0x12345FFF with `out_ready`=1:
  - First word 0x123462B7 (`out_last`=0), then 0xFFF28293 (`out_last`=1).
  - `in_ready`=0 during HOLD2.
- LI x6, 0x00001000 -> single LUI word 0x00001337, `out_last`=1. BEQ x1, x2, -4 -> 0xFE208EE3. SRAI x1, x1, 3 (`alt`=1) -> 0x4030D093.
- Backpressure: hold `out_ready`=0 for 3 cycles after a word is produced -> `out_ins` and `out_valid` are unchanged and `in_ready`=0. Release -> the next queued request is accepted in the same cycle.
- Illegal requests -> `err` pulses 1 cycle, no `out_valid`, and the next legal request is encoded normally:
  - BRANCH with `imm`=3.
  - ADDI with `imm`=2048.
  - `op_class`=12.
- Deassert `nReset` during HOLD2 -> `out_valid` drops without waiting for a clock. After release, no second LI word appears and `in_ready`=1.
